// File: rtl/accum_feeder_pkg.sv
// Shared definitions for the accumulator feeder: state encoding and bench clock period.
package accum_feeder_pkg;

  localparam int unsigned CLK_PERIOD = 10;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] S_FEED   = 2'd1;
  localparam logic [STATE_W-1:0] S_SETTLE = 2'd2;
  localparam logic [STATE_W-1:0] S_CHECK  = 2'd3;

endpackage

// File: rtl/accum_step_sel.sv
// Chunk selector: min(remaining, step) with the step zero-extended to the data width.
module accum_step_sel #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STEP_WIDTH = 6
) (
  input  logic [DATA_WIDTH-1:0] i_remaining,
  input  logic [STEP_WIDTH-1:0] i_step,
  output logic [DATA_WIDTH-1:0] o_chunk_c
);

  logic [DATA_WIDTH-1:0] w_step_ext;

  assign w_step_ext = DATA_WIDTH'(i_step);
  assign o_chunk_c  = (i_remaining < w_step_ext) ? i_remaining : w_step_ext;

endmodule

// File: rtl/accum_feeder.sv
// Drives the accumulator with a burst of bounded addends totalling a requested amount,
// then checks the accumulator sum against base + total.
module accum_feeder
  import accum_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STEP_WIDTH = 6
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] total,
  input  logic [STEP_WIDTH-1:0] step_max,
  input  logic [DATA_WIDTH-1:0] sum,
  output logic [DATA_WIDTH-1:0] addend,
  output logic                  Add,
  output logic                  busy,
  output logic                  done,
  output logic                  mismatch
);

  logic [STATE_W-1:0]    r_state;
  logic [DATA_WIDTH-1:0] r_remaining;
  logic [STEP_WIDTH-1:0] r_step;
  logic [DATA_WIDTH-1:0] r_base;
  logic [DATA_WIDTH-1:0] r_total;

  logic [STATE_W-1:0]    w_state_nxt;
  logic [DATA_WIDTH-1:0] w_rem_nxt;
  logic [STEP_WIDTH-1:0] w_step_nxt;
  logic [DATA_WIDTH-1:0] w_base_nxt;
  logic [DATA_WIDTH-1:0] w_total_nxt;
  logic                  w_clr_mis;
  logic                  w_chk;
  logic [DATA_WIDTH-1:0] w_chunk;

  // Chunk for the next cycle is computed from the post-edge remaining/step values.
  accum_step_sel #(
    .DATA_WIDTH(DATA_WIDTH),
    .STEP_WIDTH(STEP_WIDTH)
  ) u_step_sel (
    .i_remaining(w_rem_nxt),
    .i_step     (w_step_nxt),
    .o_chunk_c  (w_chunk)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_step_nxt  = r_step;
    w_base_nxt  = r_base;
    w_total_nxt = r_total;
    w_clr_mis   = 1'b0;
    w_chk       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rem_nxt   = total;
          w_step_nxt  = (step_max == '0) ? STEP_WIDTH'(1) : step_max;
          w_base_nxt  = sum;
          w_total_nxt = total;
          w_clr_mis   = 1'b1;
          w_state_nxt = (total != '0) ? S_FEED : S_SETTLE;
        end
      end
      S_FEED: begin
        // addend is the chunk currently on the bus; it never exceeds remaining
        w_rem_nxt = r_remaining - addend;
        if (addend == r_remaining) begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_chk       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_remaining <= '0;
      r_step      <= '0;
      r_base      <= '0;
      r_total     <= '0;
      Add         <= 1'b0;
      addend      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mismatch    <= 1'b0;
    end else begin
      r_remaining <= w_rem_nxt;
      r_step      <= w_step_nxt;
      r_base      <= w_base_nxt;
      r_total     <= w_total_nxt;
      Add         <= (w_state_nxt == S_FEED);
      addend      <= (w_state_nxt == S_FEED) ? w_chunk : '0;
      busy        <= (w_state_nxt != S_IDLE);
      done        <= (w_state_nxt == S_CHECK);
      if (w_clr_mis) begin
        mismatch <= 1'b0;
      end else if (w_chk) begin
        mismatch <= (sum != (r_base + r_total));
      end
    end
  end

endmodule

// File: tb/tb_accum_feeder.sv
// Randomized scoreboard bench for accum_feeder with a behavioural accumulator in front of it.
module tb_accum_feeder;
  import accum_feeder_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 6;

  typedef struct {
    int unsigned cyc;
    logic        mis;
  } res_t;

  logic          Clk;
  logic          Rst;
  logic          start;
  logic [DW-1:0] total;
  logic [SW-1:0] step_max;
  logic [DW-1:0] sum;
  logic [DW-1:0] addend;
  logic          Add;
  logic          busy;
  logic          done;
  logic          mismatch;

  accum_feeder #(.DATA_WIDTH(DW), .STEP_WIDTH(SW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .total(total), .step_max(step_max),
    .sum(sum), .addend(addend), .Add(Add), .busy(busy), .done(done), .mismatch(mismatch)
  );

  int unsigned   checks = 0;
  int unsigned   failures = 0;
  int unsigned   cyc = 0;
  logic [DW-1:0] acc = '0;
  logic          pre_en = 1'b0;
  logic [DW-1:0] pre_val = '0;
  logic          gate_block = 1'b0;

  logic [DW-1:0] exp_add_q[$];
  res_t          exp_res_q[$];
  int unsigned   busy_lo = 1, busy_hi = 0, add_hi = 0;
  logic          mis_pend = 1'b0;
  logic          mis_exp = 1'b0;

  assign sum = acc;

  initial Clk = 1'b0;
  always #(CLK_PERIOD / 2) Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural accumulator: registered sum, optional preload, Add can be gated off.
  always @(posedge Clk) begin
    if (pre_en) acc <= pre_val;
    else if (Add && !gate_block) acc <= acc + addend;
  end

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%08h expected=0x%08h", name, cyc, act, expv);
    end
  endfunction

  // Monitor: compares DUT outputs against the scoreboard queues and the expected windows.
  always @(posedge Clk) begin
    #1;
    if (!Rst) begin
      chk("busy", DW'(busy), DW'(cyc >= busy_lo && cyc <= busy_hi));
      chk("add_window", DW'(Add), DW'(cyc >= busy_lo && cyc <= add_hi));
      if (Add) begin
        if (exp_add_q.size() == 0) chk("add_unexpected", DW'(Add), '0);
        else chk("addend", addend, exp_add_q.pop_front());
      end else begin
        chk("addend_idle", addend, '0);
      end
      if (mis_pend) begin
        chk("mismatch", DW'(mismatch), DW'(mis_exp));
        mis_pend = 1'b0;
      end
      if (done) begin
        if (exp_res_q.size() == 0) begin
          chk("done_unexpected", DW'(done), '0);
        end else begin
          res_t r;
          r = exp_res_q.pop_front();
          chk("done_cycle", DW'(cyc), DW'(r.cyc));
          mis_exp  = r.mis;
          mis_pend = 1'b1;
        end
      end else if (exp_res_q.size() != 0 && cyc > exp_res_q[0].cyc) begin
        chk("done_missing", '0, DW'(1));
        void'(exp_res_q.pop_front());
      end
    end
  end

  // Preload the accumulator; called at a negedge, returns at the next negedge.
  task automatic preload(input logic [DW-1:0] v);
    pre_en  = 1'b1;
    pre_val = v;
    @(negedge Clk);
    pre_en = 1'b0;
  endtask

  // Issue one request at the current (idle) negedge; returns at the negedge of the first idle cycle.
  task automatic run_txn(input logic [DW-1:0] t, input logic [SW-1:0] sm, input bit gate,
                         input bit extra, input int unsigned rst_at);
    int unsigned   s;
    int unsigned   n;
    int unsigned   c;
    int unsigned   xpos;
    logic [DW-1:0] rem;
    logic [DW-1:0] ch;
    logic [DW-1:0] base;
    logic [DW-1:0] fin;
    res_t          r;
    s   = (sm == 0) ? 1 : int'(sm);
    rem = t;
    n   = 0;
    while (rem != 0) begin
      ch = (rem < DW'(s)) ? rem : DW'(s);
      exp_add_q.push_back(ch);
      rem = rem - ch;
      n++;
    end
    c     = cyc;
    base  = acc;
    fin   = gate ? base : base + t;
    r.cyc = c + n + 2;
    r.mis = (fin != base + t);
    exp_res_q.push_back(r);
    busy_lo    = c + 1;
    busy_hi    = c + n + 2;
    add_hi     = c + n;
    gate_block = gate;
    xpos       = $urandom_range(1, n + 2);
    start      = 1'b1;
    total      = t;
    step_max   = sm;
    for (int i = 1; i <= int'(n) + 3; i++) begin
      @(negedge Clk);
      start    = (extra && i == int'(xpos));
      total    = $urandom_range(0, 1000);
      step_max = SW'($urandom_range(0, 63));
      if (rst_at != 0 && i == int'(rst_at)) begin
        Rst = 1'b1;
        #1;
        chk("rst_add", DW'(Add), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_addend", addend, '0);
        exp_add_q.delete();
        exp_res_q.delete();
        busy_lo  = 1;
        busy_hi  = 0;
        add_hi   = 0;
        mis_pend = 1'b0;
        start    = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        repeat (8) @(negedge Clk);
        gate_block = 1'b0;
        return;
      end
    end
    chk("final_sum", acc, fin);
    gate_block = 1'b0;
  endtask

  initial begin
    Rst      = 1'b1;
    start    = 1'b0;
    total    = '0;
    step_max = '0;
    repeat (2) @(negedge Clk);
    chk("reset_add", DW'(Add), '0);
    chk("reset_addend", addend, '0);
    chk("reset_busy", DW'(busy), '0);
    chk("reset_done", DW'(done), '0);
    chk("reset_mismatch", DW'(mismatch), '0);
    Rst = 1'b0;
    @(negedge Clk);

    preload(32'h0000_0000);
    run_txn(32'd100, 6'd32, 1'b0, 1'b0, 0);
    run_txn(32'd0, 6'd5, 1'b0, 1'b0, 0);
    run_txn(32'd3, 6'd0, 1'b0, 1'b0, 0);
    preload(32'hFFFF_FFF0);
    run_txn(32'h20, 6'd32, 1'b0, 1'b0, 0);
    chk("wrap_sum", acc, 32'h0000_0010);
    preload(32'h0000_0000);
    run_txn(32'd128, 6'd32, 1'b0, 1'b0, 3);
    run_txn(32'd10, 6'd4, 1'b0, 1'b0, 0);
    run_txn(32'd50, 6'd16, 1'b1, 1'b1, 0);
    run_txn(32'd7, 6'd63, 1'b0, 1'b1, 0);

    for (int k = 0; k < 40; k++) begin
      logic [DW-1:0] t;
      if ($urandom_range(0, 5) == 0) preload(DW'($urandom()));
      t = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom_range(1, 300));
      run_txn(t, SW'($urandom_range(0, 63)), ($urandom_range(0, 6) == 0),
              ($urandom_range(0, 2) == 0), 0);
    end

    repeat (3) @(negedge Clk);
    if (exp_add_q.size() != 0 || exp_res_q.size() != 0) chk("queues_drained", '0, DW'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge Clk);
    $display("FAIL watchdog cyc=%0d expected completion earlier", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
